// File: rtl/zihpm_counter_bank_if.sv
// CSR access bus between the CSR instruction front end and the counter bank.
interface zihpm_counter_bank_if;
  logic [11:0] csr;
  logic        csr_rd_en;
  logic        csr_wr_en;
  logic [31:0] wr_val;
  logic [1:0]  priv_mode;
  logic [31:0] read_data;
  logic        invalid_csr;

  modport master (
    output csr, csr_rd_en, csr_wr_en, wr_val, priv_mode,
    input  read_data, invalid_csr
  );

  modport slave (
    input  csr, csr_rd_en, csr_wr_en, wr_val, priv_mode,
    output read_data, invalid_csr
  );
endinterface

// File: rtl/zihpm_counter_bank.sv
// Machine cycle/instret/hpm counter CSR bank with inhibit, counter-enable,
// event select, sticky overflow flags and local overflow interrupt.
module zihpm_counter_bank #(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8,
  parameter int EVT_SEL_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  zihpm_counter_bank_if.slave   bus,
  input  logic                  instr_retired,
  input  logic [NUM_EVENTS-1:0] event_vec,
  output logic                  lcof_irq
);
  localparam int NC = NUM_HPM + 3;
  localparam int W  = CNT_WIDTH;

  function automatic logic [31:0] impl_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++)
      if (i == 0 || (i >= 2 && i < NC)) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] IMPL = impl_mask();

  logic [W-1:0]         cnt [NC];
  logic [EVT_SEL_W-1:0] sel [NUM_HPM];
  logic [NUM_HPM-1:0]   of;
  logic [31:0]          inhibit;
  logic [31:0]          counteren;

  logic [4:0]  idx;
  logic [6:0]  blk;
  logic        idx_map;
  logic        m_lo, m_hi, u_lo, u_hi;
  logic        evt_a, inh_a, en_a;
  logic        is_m, bad, wr_ok;
  logic [63:0] cnt_sel;
  logic [31:0] evt_rd, rd;

  logic [NC-1:0]      inc, wr_lo, wr_hi;
  logic [NUM_HPM-1:0] evt_hit, evt_wr, of_set;

  // Address decode; index 1 (time) belongs to another unit.
  assign idx     = bus.csr[4:0];
  assign blk     = bus.csr[11:5];
  assign idx_map = idx != 5'd1;
  assign m_lo    = blk == 7'h58 && idx_map;
  assign m_hi    = blk == 7'h5C && idx_map;
  assign u_lo    = blk == 7'h60 && idx_map;
  assign u_hi    = blk == 7'h64 && idx_map;
  assign evt_a   = blk == 7'h19 && idx >= 5'd3;
  assign inh_a   = bus.csr == 12'h320;
  assign en_a    = bus.csr == 12'h306;
  assign is_m    = bus.priv_mode == 2'd3;

  assign bad =
    ((u_lo | u_hi) &
     (bus.csr_wr_en | (~is_m & ~counteren[idx]))) |
    ((m_lo | m_hi | evt_a | inh_a | en_a) & ~is_m);

  assign wr_ok = bus.csr_wr_en & ~bad;

  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < NC; i++)
      if (IMPL[i] && idx == 5'(i)) cnt_sel = 64'(cnt[i]);
    evt_rd = '0;
    for (int i = 0; i < NUM_HPM; i++)
      if (idx == 5'(i + 3)) evt_rd = {of[i], 31'(sel[i])};
  end

  always_comb begin
    rd = '0;
    unique case (1'b1)
      m_lo, u_lo: rd = cnt_sel[31:0];
      m_hi, u_hi: rd = cnt_sel[63:32];
      evt_a:      rd = evt_rd;
      inh_a:      rd = inhibit;
      en_a:       rd = counteren;
      default:    rd = '0;
    endcase
  end

  assign bus.read_data   = (bus.csr_rd_en && !bad) ? rd : 32'd0;
  assign bus.invalid_csr = bus.csr_rd_en & bad;

  always_comb begin
    evt_hit = '0;
    for (int i = 0; i < NUM_HPM; i++)
      for (int e = 0; e < NUM_EVENTS; e++)
        if (int'(sel[i]) == e + 1 && event_vec[e])
          evt_hit[i] = 1'b1;
  end

  always_comb begin
    inc    = '0;
    wr_lo  = '0;
    wr_hi  = '0;
    evt_wr = '0;
    of_set = '0;
    inc[0] = ~inhibit[0];
    inc[2] = instr_retired & ~inhibit[2];
    for (int i = 0; i < NC; i++) begin
      wr_lo[i] = wr_ok & m_lo & (idx == 5'(i)) & IMPL[i];
      wr_hi[i] = wr_ok & m_hi & (idx == 5'(i)) & IMPL[i];
    end
    for (int i = 0; i < NUM_HPM; i++) begin
      inc[i+3]  = evt_hit[i] & ~inhibit[i+3];
      evt_wr[i] = wr_ok & evt_a & (idx == 5'(i + 3));
      // A software write to the counter swallows the increment, so no wrap.
      of_set[i] = inc[i+3] & ~wr_lo[i+3] & ~wr_hi[i+3] & (&cnt[i+3]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NC; i++) cnt[i] <= '0;
      for (int i = 0; i < NUM_HPM; i++) sel[i] <= '0;
      of        <= '0;
      inhibit   <= '0;
      counteren <= '0;
      lcof_irq  <= 1'b0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (!IMPL[i])
          cnt[i] <= '0;
        else if (wr_lo[i])
          cnt[i][31:0] <= bus.wr_val;
        else if (wr_hi[i])
          cnt[i][W-1:32] <= bus.wr_val[W-33:0];
        else if (inc[i])
          cnt[i] <= cnt[i] + W'(1);
      end
      for (int i = 0; i < NUM_HPM; i++) begin
        if (evt_wr[i]) sel[i] <= bus.wr_val[EVT_SEL_W-1:0];
        of[i] <= of_set[i] | (evt_wr[i] ? bus.wr_val[31] : of[i]);
      end
      if (wr_ok && inh_a) inhibit <= bus.wr_val & IMPL;
      if (wr_ok && en_a) counteren <= bus.wr_val & IMPL;
      lcof_irq <= |of;
    end
  end
endmodule
